// File: rtl/wb_store_buffer_if.sv
// Bus bundle between writeback/mem stage, the store buffer and the dcache write port.
// STORE_FWD_EN adds the load-forwarding signals.
interface wb_store_buffer_if #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              WB_wr_valid;
   logic [ADDR_W-1:0] WB_wr_address;
   logic [DATA_W-1:0] WB_wr_data;
   logic [1:0]        WB_wr_size;
   logic              In_write_ready;
   logic              DC_wr_req;
   logic [ADDR_W-1:0] DC_wr_address;
   logic [DATA_W-1:0] DC_wr_data;
   logic [1:0]        DC_wr_size;
   logic              DC_wr_ack;
   logic [ADDR_W-1:0] LD_check_address;
   logic [1:0]        LD_check_size;
   logic              LD_conflict;
   logic              SB_empty;
   logic [CNT_W-1:0]  SB_count;
`ifdef STORE_FWD_EN
   logic              LD_fwd_hit;
   logic [DATA_W-1:0] LD_fwd_data;
`endif

   modport slave (
`ifdef STORE_FWD_EN
      output LD_fwd_hit,
      output LD_fwd_data,
`endif
      input  WB_wr_valid,
      input  WB_wr_address,
      input  WB_wr_data,
      input  WB_wr_size,
      output In_write_ready,
      output DC_wr_req,
      output DC_wr_address,
      output DC_wr_data,
      output DC_wr_size,
      input  DC_wr_ack,
      input  LD_check_address,
      input  LD_check_size,
      output LD_conflict,
      output SB_empty,
      output SB_count
   );

   modport master (
`ifdef STORE_FWD_EN
      input  LD_fwd_hit,
      input  LD_fwd_data,
`endif
      output WB_wr_valid,
      output WB_wr_address,
      output WB_wr_data,
      output WB_wr_size,
      input  In_write_ready,
      input  DC_wr_req,
      input  DC_wr_address,
      input  DC_wr_data,
      input  DC_wr_size,
      output DC_wr_ack,
      output LD_check_address,
      output LD_check_size,
      input  LD_conflict,
      input  SB_empty,
      input  SB_count
   );
endinterface

// File: rtl/wb_store_buffer.sv
// In-order posted-write queue from writeback to the dcache write port with load-overlap detection.
// Define STORE_FWD_EN to forward data from the youngest exactly-matching pending store.
module wb_store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input logic              CLK,
   input logic              CLR,
   wb_store_buffer_if.slave sb
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [1:0]        size_q [DEPTH];
   logic [1:0]        size_d [DEPTH];
   logic              enq, deq;
   logic [DEPTH-1:0]  overlap;

   // A full queue refuses stores even when the head drains this cycle.
   assign enq = sb.WB_wr_valid && (count_q != FULL);
   assign deq = (state_q == ISSUE) && sb.DC_wr_ack;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      size_d  = size_q;
      if (deq) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
      end
      if (enq) begin
         valid_d[tail_q] = 1'b1;
         addr_d[tail_q]  = sb.WB_wr_address;
         data_d[tail_q]  = sb.WB_wr_data;
         size_d[tail_q]  = sb.WB_wr_size;
         tail_d          = tail_q + 1'b1;
      end
      case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      state_d = (count_d != '0) ? ISSUE : IDLE;
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state_q <= IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         addr_q  <= '{default: '0};
         data_q  <= '{default: '0};
         size_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         size_q  <= size_d;
      end
   end

   assign sb.In_write_ready = (count_q != FULL);
   assign sb.DC_wr_req      = (state_q == ISSUE);
   assign sb.DC_wr_address  = (state_q == ISSUE) ? addr_q[head_q] : '0;
   assign sb.DC_wr_data     = (state_q == ISSUE) ? data_q[head_q] : '0;
   assign sb.DC_wr_size     = (state_q == ISSUE) ? size_q[head_q] : '0;
   assign sb.SB_empty       = (count_q == '0);
   assign sb.SB_count       = count_q;

   // Qword-granular compare; includes the head even while it is being acked.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ovl
      assign overlap[gi] = valid_q[gi] &&
                           (addr_q[gi][ADDR_W-1:3] == sb.LD_check_address[ADDR_W-1:3]);
   end

`ifdef STORE_FWD_EN
   logic [PTR_W-1:0] young_idx;
   logic             young_found;
   logic             exact;

   // Walk oldest to youngest so the last overlapping hit is the one nearest the tail.
   always_comb begin
      young_idx   = head_q;
      young_found = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (overlap[head_q + PTR_W'(k)]) begin
            young_idx   = head_q + PTR_W'(k);
            young_found = 1'b1;
         end
      end
   end

   assign exact = young_found &&
                  (addr_q[young_idx] == sb.LD_check_address) &&
                  (size_q[young_idx] == sb.LD_check_size);
   assign sb.LD_fwd_hit  = exact;
   assign sb.LD_fwd_data = exact ? data_q[young_idx] : '0;
   assign sb.LD_conflict = young_found && !exact;
`else
   logic ld_unused;
   assign ld_unused      = ^{sb.LD_check_address[2:0], sb.LD_check_size};
   assign sb.LD_conflict = |overlap;
`endif
endmodule

// File: tb/tb_wb_store_buffer.sv
// Self-checking bench for wb_store_buffer: a negedge monitor scoreboards enqueued stores
// against dcache drains; scenario tasks check flags, occupancy and overlap inline.
module tb_wb_store_buffer;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [1:0]        size;
   } st_t;

   logic clk;
   logic clr;
   int   checks   = 0;
   int   failures = 0;
   st_t  sb_q[$];
   st_t  mon_exp;
   st_t  mon_got;

   wb_store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) sbi ();

   wb_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .CLK (clk),
      .CLR (clr),
      .sb  (sbi)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   // Scoreboard: pop on drain handshake first (older entry), then push on accepted store.
   always @(negedge clk) begin
      if (clr) begin
         sb_q.delete();
      end else begin
         if (sbi.DC_wr_req && sbi.DC_wr_ack) begin
            checks++;
            mon_got = '{addr: sbi.DC_wr_address, data: sbi.DC_wr_data, size: sbi.DC_wr_size};
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL drain_unexpected: got addr=%h data=%h, required no request",
                        mon_got.addr, mon_got.data);
            end else begin
               mon_exp = sb_q.pop_front();
               if (mon_got !== mon_exp) begin
                  failures++;
                  $display("FAIL drain_order: got addr=%h data=%h size=%0d, required addr=%h data=%h size=%0d",
                           mon_got.addr, mon_got.data, mon_got.size,
                           mon_exp.addr, mon_exp.data, mon_exp.size);
               end else begin
                  $display("drain addr=%h data=%h size=%0d", mon_got.addr, mon_got.data, mon_got.size);
               end
            end
         end
         if (sbi.WB_wr_valid && sbi.In_write_ready) begin
            sb_q.push_back('{addr: sbi.WB_wr_address, data: sbi.WB_wr_data, size: sbi.WB_wr_size});
            $display("enq   addr=%h data=%h size=%0d", sbi.WB_wr_address, sbi.WB_wr_data, sbi.WB_wr_size);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [1:0] s);
      sbi.WB_wr_valid   = 1'b1;
      sbi.WB_wr_address = a;
      sbi.WB_wr_data    = d;
      sbi.WB_wr_size    = s;
   endtask

   task automatic drain_all();
      sbi.WB_wr_valid = 1'b0;
      sbi.DC_wr_ack   = 1'b1;
      for (int n = 0; n < 4 * DEPTH && sbi.SB_empty !== 1'b1; n++) tick();
      sbi.DC_wr_ack = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      clr = 1'b1;
      tick();
      tick();
      clr = 1'b0;
      #1;
      checks++;
      if (sbi.DC_wr_req !== 1'b0 || sbi.DC_wr_address !== '0 || sbi.DC_wr_data !== '0 || sbi.DC_wr_size !== 2'd0) begin
         failures++;
         $display("FAIL reset_dc: got req=%b addr=%h data=%h size=%0d, required all 0",
                  sbi.DC_wr_req, sbi.DC_wr_address, sbi.DC_wr_data, sbi.DC_wr_size);
      end
      checks++;
      if (sbi.In_write_ready !== 1'b1 || sbi.SB_empty !== 1'b1 || sbi.SB_count !== 3'd0 || sbi.LD_conflict !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags: got ready=%b empty=%b count=%0d conflict=%b, required 1 1 0 0",
                  sbi.In_write_ready, sbi.SB_empty, sbi.SB_count, sbi.LD_conflict);
      end
`ifdef STORE_FWD_EN
      checks++;
      if (sbi.LD_fwd_hit !== 1'b0 || sbi.LD_fwd_data !== '0) begin
         failures++;
         $display("FAIL reset_fwd: got hit=%b data=%h, required 0 0", sbi.LD_fwd_hit, sbi.LD_fwd_data);
      end
`endif
   endtask

   task automatic test_single();
      sbi.DC_wr_ack = 1'b1;
      set_store(32'h1000, 64'hAB, 2'd0);
      #1;
      checks++;
      if (sbi.DC_wr_req !== 1'b0) begin
         failures++;
         $display("FAIL single_latency: got req=%b in enqueue cycle, required 0", sbi.DC_wr_req);
      end
      tick();
      sbi.WB_wr_valid = 1'b0;
      #1;
      checks++;
      if (sbi.DC_wr_req !== 1'b1 || sbi.DC_wr_address !== 32'h1000 || sbi.SB_count !== 3'd1) begin
         failures++;
         $display("FAIL single_issue: got req=%b addr=%h count=%0d, required 1 00001000 1",
                  sbi.DC_wr_req, sbi.DC_wr_address, sbi.SB_count);
      end
      tick();
      checks++;
      if (sbi.SB_empty !== 1'b1 || sbi.DC_wr_req !== 1'b0) begin
         failures++;
         $display("FAIL single_empty: got empty=%b req=%b, required 1 0", sbi.SB_empty, sbi.DC_wr_req);
      end
      sbi.DC_wr_ack = 1'b0;
   endtask

   task automatic test_full();
      sbi.DC_wr_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_store(32'h4000 + 32'(8 * i), 64'h100 + 64'(i), 2'(i));
         #1;
         checks++;
         if (sbi.In_write_ready !== (i < 4)) begin
            failures++;
            $display("FAIL full_ready%0d: got ready=%b, required %b", i, sbi.In_write_ready, (i < 4));
         end
         tick();
      end
      checks++;
      if (sbi.SB_count !== 3'd4 || sbi.In_write_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_count: got count=%0d ready=%b, required 4 0", sbi.SB_count, sbi.In_write_ready);
      end
      sbi.DC_wr_ack = 1'b1;
      #1;
      checks++;
      if (sbi.In_write_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_no_writethrough: got ready=%b during ack, required 0", sbi.In_write_ready);
      end
      tick();
      sbi.DC_wr_ack = 1'b0;
      #1;
      checks++;
      if (sbi.In_write_ready !== 1'b1 || sbi.SB_count !== 3'd3) begin
         failures++;
         $display("FAIL full_after_ack: got ready=%b count=%0d, required 1 3", sbi.In_write_ready, sbi.SB_count);
      end
      tick();
      sbi.WB_wr_valid = 1'b0;
      #1;
      checks++;
      if (sbi.SB_count !== 3'd4) begin
         failures++;
         $display("FAIL full_refill: got count=%0d, required 4", sbi.SB_count);
      end
      drain_all();
      checks++;
      if (sbi.SB_empty !== 1'b1 || sb_q.size() != 0) begin
         failures++;
         $display("FAIL full_drain: got empty=%b pending=%0d, required 1 0", sbi.SB_empty, sb_q.size());
      end
   endtask

   task automatic test_back_to_back();
      sbi.DC_wr_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_store(32'h6000 + 32'(8 * i), 64'hC0DE_0000 + 64'(i), 2'd3);
         tick();
      end
      sbi.DC_wr_ack = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_store(32'h6100 + 32'(8 * i), 64'hBEEF_0000 + 64'(i), 2'(i));
         tick();
         checks++;
         if (sbi.SB_count !== 3'd2 || sbi.DC_wr_req !== 1'b1) begin
            failures++;
            $display("FAIL b2b_count%0d: got count=%0d req=%b, required 2 1", i, sbi.SB_count, sbi.DC_wr_req);
         end
      end
      drain_all();
      checks++;
      if (sbi.SB_empty !== 1'b1 || sb_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_drain: got empty=%b pending=%0d, required 1 0", sbi.SB_empty, sb_q.size());
      end
   endtask

   task automatic test_conflict();
      sbi.DC_wr_ack = 1'b0;
      set_store(32'h2004, 64'h55, 2'd2);
      tick();
      sbi.WB_wr_valid      = 1'b0;
      sbi.LD_check_address = 32'h2000;
      sbi.LD_check_size    = 2'd3;
      #1;
      checks++;
      if (sbi.LD_conflict !== 1'b1) begin
         failures++;
         $display("FAIL conflict_same_qword: got %b, required 1", sbi.LD_conflict);
      end
      sbi.LD_check_address = 32'h2008;
      #1;
      checks++;
      if (sbi.LD_conflict !== 1'b0) begin
         failures++;
         $display("FAIL conflict_next_qword: got %b, required 0", sbi.LD_conflict);
      end
      sbi.LD_check_address = 32'h2007;
      sbi.LD_check_size    = 2'd0;
      #1;
      checks++;
      if (sbi.LD_conflict !== 1'b1) begin
         failures++;
         $display("FAIL conflict_qword_edge: got %b, required 1", sbi.LD_conflict);
      end
      sbi.LD_check_address = 32'h2000;
      sbi.DC_wr_ack        = 1'b1;
      #1;
      checks++;
      if (sbi.LD_conflict !== 1'b1) begin
         failures++;
         $display("FAIL conflict_head_acked: got %b, required 1", sbi.LD_conflict);
      end
      tick();
      sbi.DC_wr_ack = 1'b0;
      #1;
      checks++;
      if (sbi.LD_conflict !== 1'b0 || sbi.SB_empty !== 1'b1) begin
         failures++;
         $display("FAIL conflict_after_drain: got conflict=%b empty=%b, required 0 1", sbi.LD_conflict, sbi.SB_empty);
      end
      sbi.LD_check_address = '0;
   endtask

`ifdef STORE_FWD_EN
   task automatic test_forward();
      sbi.DC_wr_ack = 1'b0;
      set_store(32'h3000, 64'h11, 2'd2);
      tick();
      set_store(32'h3000, 64'h22, 2'd2);
      tick();
      sbi.WB_wr_valid      = 1'b0;
      sbi.LD_check_address = 32'h3000;
      sbi.LD_check_size    = 2'd2;
      #1;
      checks++;
      if (sbi.LD_fwd_hit !== 1'b1 || sbi.LD_fwd_data !== 64'h22 || sbi.LD_conflict !== 1'b0) begin
         failures++;
         $display("FAIL fwd_hit: got hit=%b data=%h conflict=%b, required 1 22 0",
                  sbi.LD_fwd_hit, sbi.LD_fwd_data, sbi.LD_conflict);
      end
      sbi.LD_check_size = 2'd0;
      #1;
      checks++;
      if (sbi.LD_fwd_hit !== 1'b0 || sbi.LD_conflict !== 1'b1) begin
         failures++;
         $display("FAIL fwd_size_miss: got hit=%b conflict=%b, required 0 1", sbi.LD_fwd_hit, sbi.LD_conflict);
      end
      sbi.LD_check_address = '0;
      drain_all();
   endtask
`endif

   task automatic test_reset_mid_drain();
      sbi.DC_wr_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_store(32'h5000 + 32'(8 * i), 64'hD00D + 64'(i), 2'd1);
         tick();
      end
      sbi.WB_wr_valid = 1'b0;
      #1;
      checks++;
      if (sbi.DC_wr_req !== 1'b1 || sbi.SB_count !== 3'd3) begin
         failures++;
         $display("FAIL rst_mid_pre: got req=%b count=%0d, required 1 3", sbi.DC_wr_req, sbi.SB_count);
      end
      clr = 1'b1;
      #1;
      checks++;
      if (sbi.DC_wr_req !== 1'b0 || sbi.In_write_ready !== 1'b1 || sbi.SB_count !== 3'd0 || sbi.SB_empty !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_async: got req=%b ready=%b count=%0d empty=%b, required 0 1 0 1",
                  sbi.DC_wr_req, sbi.In_write_ready, sbi.SB_count, sbi.SB_empty);
      end
      tick();
      clr           = 1'b0;
      sbi.DC_wr_ack = 1'b1;
      tick();
      tick();
      checks++;
      if (sbi.DC_wr_req !== 1'b0 || sbi.SB_count !== 3'd0 || sbi.DC_wr_address !== '0) begin
         failures++;
         $display("FAIL rst_mid_ack_ignored: got req=%b count=%0d addr=%h, required 0 0 0",
                  sbi.DC_wr_req, sbi.SB_count, sbi.DC_wr_address);
      end
      sbi.DC_wr_ack = 1'b0;
   endtask

   initial begin
      clr                  = 1'b1;
      sbi.WB_wr_valid      = 1'b0;
      sbi.WB_wr_address    = '0;
      sbi.WB_wr_data       = '0;
      sbi.WB_wr_size       = '0;
      sbi.DC_wr_ack        = 1'b0;
      sbi.LD_check_address = '0;
      sbi.LD_check_size    = '0;
      test_reset();
      test_single();
      test_full();
      test_back_to_back();
      test_conflict();
`ifdef STORE_FWD_EN
      test_forward();
`endif
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
